// File: rtl/ddr2_test_seq_ctrl.sv
// ddr2_test_seq_ctrl: DDR2 self-test traffic sequencer.
// Writes NUM_BURSTS two-beat bursts of a byte-replicated counting pattern
// through the app FIFOs. It then reads the bursts back and presents the
// expected beat on app_compare_data one cycle after each read_data_valid.
// It also folds the compare block's sticky error into test_done and test_pass.
// Optional feature macro: TEST_TIMEOUT_EN adds a read watchdog (TIMEOUT_CYC cycles).
module ddr2_test_seq_ctrl #(
  parameter int DQ_WIDTH    = 32,
  parameter int ADDR_WIDTH  = 31,
  parameter int NUM_BURSTS  = 16,
  parameter int ADDR_STEP   = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init_done,
  input  logic                    run_continuous,
  input  logic                    app_af_afull,
  input  logic                    app_wdf_afull,
  input  logic                    read_data_valid,
  input  logic                    error,
  output logic                    app_af_wren,
  output logic [2:0]              app_af_cmd,
  output logic [ADDR_WIDTH-1:0]   app_af_addr,
  output logic                    app_wdf_wren,
  output logic [2*DQ_WIDTH-1:0]   app_wdf_data,
  output logic [DQ_WIDTH/4-1:0]   app_wdf_mask_data,
  output logic [2*DQ_WIDTH-1:0]   app_compare_data,
  output logic                    test_done,
  output logic                    test_pass,
  output logic                    test_timeout,
  output logic [15:0]             pass_count
);

  localparam int         BEAT_W      = 2 * DQ_WIDTH;
  localparam int         BYTES       = DQ_WIDTH / 8;
  localparam logic [8:0] LAST_BURST  = 9'(NUM_BURSTS - 1);
  localparam logic [9:0] TOTAL_BEATS = 10'(2 * NUM_BURSTS);
  localparam logic [7:0] SEED_STEP   = 8'(2 * NUM_BURSTS);
  localparam logic [2:0] CMD_WRITE   = 3'b000;
  localparam logic [2:0] CMD_READ    = 3'b001;

  // Reject configurations the counters cannot represent.
  if (NUM_BURSTS < 1 || NUM_BURSTS > 256 || (DQ_WIDTH % 8) != 0 ||
      TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_param
    $error("ddr2_test_seq_ctrl: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT_RD, DONE} state_t;

  state_t     state;
  logic [7:0] seed;          // pattern value of beat 0 in the current pass
  logic [7:0] wk;            // write beat index, only the low byte matters
  logic [8:0] burst_idx;     // burst counter, reused for write then read commands
  logic       second_beat;   // next write beat is the 2nd of its burst
  logic [9:0] rk;            // read beats received this pass
  logic       rd_accept;

  // Beat k: every rise byte is k, every fall byte is ~k.
  function automatic logic [BEAT_W-1:0] pattern(input logic [7:0] k);
    return {{BYTES{k}}, {BYTES{~k}}};
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] burst_addr(input logic [8:0] idx);
    return ADDR_WIDTH'(idx) * ADDR_WIDTH'(ADDR_STEP);
  endfunction

  // Read beats may arrive while commands are still being issued, so any active
  // state counts them; surplus beats beyond the pass total are dropped.
  assign rd_accept = read_data_valid && (rk != TOTAL_BEATS) &&
                     (state == WRITE || state == READ || state == WAIT_RD);

  assign app_wdf_mask_data = '0;

`ifdef TEST_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] wd_cnt;
`else
  assign test_timeout = 1'b0;
`endif

  // Sequencer FSM with registered strobes, pattern data and pass status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      seed             <= '0;
      wk               <= '0;
      burst_idx        <= '0;
      second_beat      <= 1'b0;
      rk               <= '0;
      app_af_wren      <= 1'b0;
      app_af_cmd       <= '0;
      app_af_addr      <= '0;
      app_wdf_wren     <= 1'b0;
      app_wdf_data     <= '0;
      app_compare_data <= '0;
      test_done        <= 1'b0;
      test_pass        <= 1'b0;
      pass_count       <= '0;
`ifdef TEST_TIMEOUT_EN
      test_timeout     <= 1'b0;
      wd_cnt           <= '0;
`endif
    end else begin
      app_af_wren  <= 1'b0;
      app_wdf_wren <= 1'b0;

      if (rd_accept) begin
        app_compare_data <= pattern(seed + rk[7:0]);
        rk               <= rk + 10'd1;
      end

      case (state)
        IDLE: begin
          if (init_done) state <= WRITE;
        end

        WRITE: begin
          // The 2nd beat and its write command go out together or not at all.
          if (!app_wdf_afull && (!second_beat || !app_af_afull)) begin
            app_wdf_wren <= 1'b1;
            app_wdf_data <= pattern(seed + wk);
            wk           <= wk + 8'd1;
            second_beat  <= ~second_beat;
            if (second_beat) begin
              app_af_wren <= 1'b1;
              app_af_cmd  <= CMD_WRITE;
              app_af_addr <= burst_addr(burst_idx);
              if (burst_idx == LAST_BURST) begin
                burst_idx <= '0;
                state     <= READ;
              end else begin
                burst_idx <= burst_idx + 9'd1;
              end
            end
          end
        end

        READ: begin
          if (!app_af_afull) begin
            app_af_wren <= 1'b1;
            app_af_cmd  <= CMD_READ;
            app_af_addr <= burst_addr(burst_idx);
            if (burst_idx == LAST_BURST) begin
              burst_idx <= '0;
              state     <= WAIT_RD;
            end else begin
              burst_idx <= burst_idx + 9'd1;
            end
          end
        end

        WAIT_RD: begin
          if (rk == TOTAL_BEATS) begin
            state      <= DONE;
            test_done  <= 1'b1;
            test_pass  <= !error;
            pass_count <= pass_count + 16'd1;
`ifdef TEST_TIMEOUT_EN
            wd_cnt     <= '0;
          end else if (!read_data_valid && wd_cnt == WD_LAST) begin
            state        <= DONE;
            test_done    <= 1'b1;
            test_pass    <= 1'b0;
            test_timeout <= 1'b1;
            pass_count   <= pass_count + 16'd1;
            wd_cnt       <= '0;
          end else if (read_data_valid) begin
            wd_cnt <= '0;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
`endif
          end
        end

        DONE: begin
          if (run_continuous) begin
            state       <= WRITE;
            seed        <= seed + SEED_STEP;
            wk          <= '0;
            rk          <= '0;
            burst_idx   <= '0;
            second_beat <= 1'b0;
            test_done   <= 1'b0;
            test_pass   <= 1'b0;
`ifdef TEST_TIMEOUT_EN
            test_timeout <= 1'b0;
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
